// File: rtl/risc16_pkg.sv
// risc16_pkg: shared state encodings and wait-code constants for the RiSC-16 core
package risc16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } state_t;

    localparam logic [1:0] WAIT_2CYC = 2'b00;
    localparam logic [1:0] WAIT_3CYC = 2'b01;
    localparam logic [1:0] WAIT_4CYC = 2'b10;

endpackage

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle timing engine for the RiSC-16 core
//   clk, rst_n          clock, async active-low reset
//   run, halt_req       run level and single-cycle halt request
//   imem_ready          instruction memory data valid
//   wait_cycle          extra execute cycles for current opcode
//   werf_in, wedmem_in  decoder write enables (active-low)
//   ir_we, pc_we        IR load and PC update strobes
//   werf_n, wedmem_n    write enables gated to the commit cycle (active-low)
//   busy, instr_done    not idle; one-cycle commit pulse
//   instret             retired-instruction counter (wraps)
module cycle_sequencer
    import risc16_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int WAIT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt_req,
    input  logic              imem_ready,
    input  logic [WAIT_W-1:0] wait_cycle,
    input  logic              werf_in,
    input  logic              wedmem_in,
    output logic              ir_we,
    output logic              pc_we,
    output logic              werf_n,
    output logic              wedmem_n,
    output logic              busy,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instret
);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt, cnt_nx;
    logic              halt_pend, halt_pend_nx;
    logic              commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            halt_pend <= 1'b0;
            instret   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            halt_pend <= halt_pend_nx;
            if (commit)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        halt_pend_nx = halt_pend;
        commit       = 1'b0;
        ir_we        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && !halt_pend)
                    state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                ir_we        = imem_ready;
                halt_pend_nx = halt_pend | halt_req;
                if (imem_ready) begin
                    state_nx = ST_EXEC;
                    cnt_nx   = '0;
                end
            end
            ST_EXEC: begin
                // wait_cycle is compared live: the IR is stable throughout EXEC
                if (cnt != wait_cycle) begin
                    cnt_nx       = cnt + 1'b1;
                    halt_pend_nx = halt_pend | halt_req;
                end else begin
                    commit   = 1'b1;
                    state_nx = (!run || halt_pend || halt_req) ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // a pending halt is consumed by reaching IDLE
        if (state_nx == ST_IDLE)
            halt_pend_nx = 1'b0;
    end

    assign pc_we      = commit;
    assign instr_done = commit;
    assign werf_n     = commit ? werf_in : 1'b1;
    assign wedmem_n   = commit ? wedmem_in : 1'b1;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        halt_req;
    logic        imem_ready;
    logic [1:0]  wait_cycle;
    logic        werf_in;
    logic        wedmem_in;
    logic        ir_we, pc_we, werf_n, wedmem_n, busy, instr_done;
    logic [15:0] instret;
    logic        w_ir_we, w_pc_we, w_werf_n, w_wedmem_n, w_busy, w_instr_done;
    logic [3:0]  w_instret;
    logic [5:0]  obs;
    logic [2:0]  obs3;
    int          tests;
    int          fails;

    assign obs  = {ir_we, pc_we, werf_n, wedmem_n, busy, instr_done};
    assign obs3 = {ir_we, pc_we, busy};

    cycle_sequencer #(.CNT_W(16), .WAIT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_ready(imem_ready), .wait_cycle(wait_cycle),
        .werf_in(werf_in), .wedmem_in(wedmem_in),
        .ir_we(ir_we), .pc_we(pc_we), .werf_n(werf_n), .wedmem_n(wedmem_n),
        .busy(busy), .instr_done(instr_done), .instret(instret)
    );

    cycle_sequencer #(.CNT_W(4), .WAIT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .imem_ready(imem_ready), .wait_cycle(wait_cycle),
        .werf_in(werf_in), .wedmem_in(wedmem_in),
        .ir_we(w_ir_we), .pc_we(w_pc_we), .werf_n(w_werf_n), .wedmem_n(w_wedmem_n),
        .busy(w_busy), .instr_done(w_instr_done), .instret(w_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n      = 1'b0;
        run        = 1'b0;
        halt_req   = 1'b0;
        imem_ready = 1'b0;
        wait_cycle = 2'b00;
        werf_in    = 1'b1;
        wedmem_in  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; werf_in = 1'b0; wedmem_in = 1'b0;
        #3;
        tests++;
        if (obs !== 6'b001100) begin
            fails++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b001100);
        end
        @(posedge clk); #1;
        tests++;
        if (instret !== 16'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_hold: instret=%0d busy=%b expected 0/0", instret, busy);
        end
    endtask

    task automatic test_single;
        logic [5:0] exp [4];
        exp = '{6'b001100, 6'b101110, 6'b001110, 6'b010111};
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b01; werf_in = 1'b0; wedmem_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (obs !== exp[c]) begin
                fails++; $display("FAIL single c%0d: got %b expected %b", c, obs, exp[c]);
            end
            if (c == 3) begin
                tests++;
                if (instret !== 16'd0) begin
                    fails++; $display("FAIL single_precommit_instret: got %0d expected 0", instret);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++;
        if (instret !== 16'd1) begin
            fails++; $display("FAIL single_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] w [10];
        logic [2:0] exp [10];
        w   = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
        exp = '{3'b000, 3'b101, 3'b011, 3'b101, 3'b001, 3'b001, 3'b011, 3'b101, 3'b001, 3'b011};
        do_reset;
        run = 1'b1; imem_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wait_cycle = w[c];
            @(negedge clk);
            tests++;
            if (obs3 !== exp[c]) begin
                fails++; $display("FAIL b2b c%0d: got %b expected %b", c, obs3, exp[c]);
            end
            @(posedge clk); #1;
        end
        run = 1'b0;
        @(negedge clk);
        tests++;
        if (instret !== 16'd3) begin
            fails++; $display("FAIL b2b_instret: got %0d expected 3", instret);
        end
    endtask

    task automatic test_wedmem_gate;
        logic exp [6];
        exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b10; wedmem_in = 1'b0; werf_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (wedmem_n !== exp[c] || werf_n !== 1'b1) begin
                fails++; $display("FAIL wedmem c%0d: wedmem_n=%b werf_n=%b expected %b/1", c, wedmem_n, werf_n, exp[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        logic       r [7];
        logic [2:0] exp [7];
        r   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b101, 3'b001, 3'b011};
        do_reset;
        run = 1'b1; wait_cycle = 2'b01;
        for (int c = 0; c < 7; c++) begin
            imem_ready = r[c];
            @(negedge clk);
            tests++;
            if (obs3 !== exp[c]) begin
                fails++; $display("FAIL stall c%0d: got %b expected %b", c, obs3, exp[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt;
        logic       h [7];
        logic [2:0] exp [7];
        h   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b011, 3'b000, 3'b101};
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b10;
        for (int c = 0; c < 7; c++) begin
            halt_req = h[c];
            @(negedge clk);
            tests++;
            if (obs3 !== exp[c]) begin
                fails++; $display("FAIL halt c%0d: got %b expected %b", c, obs3, exp[c]);
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
    endtask

    task automatic test_halt_commit;
        logic       h [5];
        logic [2:0] exp [5];
        h   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp = '{3'b000, 3'b101, 3'b011, 3'b000, 3'b101};
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b00;
        for (int c = 0; c < 5; c++) begin
            halt_req = h[c];
            @(negedge clk);
            tests++;
            if (obs3 !== exp[c]) begin
                fails++; $display("FAIL halt_commit c%0d: got %b expected %b", c, obs3, exp[c]);
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
    endtask

    task automatic test_run_drop;
        logic       rn [5];
        logic [2:0] exp [5];
        rn  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b000};
        do_reset;
        imem_ready = 1'b1; wait_cycle = 2'b01;
        for (int c = 0; c < 5; c++) begin
            run = rn[c];
            @(negedge clk);
            tests++;
            if (obs3 !== exp[c]) begin
                fails++; $display("FAIL run_drop c%0d: got %b expected %b", c, obs3, exp[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_commit;
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b01; werf_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (werf_n !== 1'b0 || pc_we !== 1'b1) begin
            fails++; $display("FAIL abort_precommit: werf_n=%b pc_we=%b expected 0/1", werf_n, pc_we);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 6'b001100) begin
            fails++; $display("FAIL abort_async: got %b expected %b", obs, 6'b001100);
        end
        @(posedge clk); #1;
        tests++;
        if (instret !== 16'd0 || busy !== 1'b0 || werf_n !== 1'b1) begin
            fails++; $display("FAIL abort_state: instret=%0d busy=%b werf_n=%b expected 0/0/1", instret, busy, werf_n);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap;
        do_reset;
        run = 1'b1; imem_ready = 1'b1; wait_cycle = 2'b00;
        repeat (31) @(posedge clk);
        @(negedge clk);
        tests++;
        if (w_instret !== 4'hF || instret !== 16'd15) begin
            fails++; $display("FAIL wrap_pre: narrow=%0d wide=%0d expected 15/15", w_instret, instret);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (w_instret !== 4'h0) begin
            fails++; $display("FAIL wrap_zero: narrow=%0d expected 0", w_instret);
        end
        tests++;
        if (instret !== 16'd16) begin
            fails++; $display("FAIL wrap_wide: got %0d expected 16", instret);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_wedmem_gate;
        test_stall;
        test_halt;
        test_halt_commit;
        test_run_drop;
        test_reset_mid_commit;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
